// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of fetch entries with synchronous clear.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    push,
    input  fetch_entry_t            push_data,
    input  logic                    pop,
    output fetch_entry_t            head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A pop on empty is ignored; a push on full is only taken when a pop frees the slot.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_COUNT) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, keeps up to DEPTH requests in flight and
// hands {inst, pc, snpc} to decode; redirects flush and drain stale responses.
module ifu_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [31:0]             imem_req_addr,
    input  logic                    imem_rsp_valid,
    input  logic [31:0]             imem_rsp_data,
    output logic [31:0]             inst,
    output logic [31:0]             pc,
    output logic [31:0]             snpc,
    output logic                    valid_next,
    input  logic                    ready_next,
    output logic [$clog2(DEPTH):0]  outstanding,
    output fetch_state_e            state,
    output logic [$clog2(DEPTH):0]  drop_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

    fetch_state_e  state_next;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] drop_next;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] pcq_count;
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          rsp_take;
    logic          rsp_keep;
    logic          pop_fire;
    fetch_entry_t  fifo_head;
    fetch_entry_t  pcq_head;
    fetch_entry_t  rsp_entry;
    fetch_entry_t  pcq_entry;
    logic          unused_pcq_inst;

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
    // depends on ready of the same channel, and the response channel has no backpressure.
    assign req_fire    = imem_req_valid && imem_req_ready;
    assign rsp_take    = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep    = rsp_take && (drop_count == '0) && !redirect_valid && (pcq_count != '0);
    assign pop_fire    = valid_next && ready_next;
    assign valid_next  = !redirect_valid && (fifo_count != '0);
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_addr = fetch_pc;
    assign snpc        = pc + 32'd4;

    assign rsp_entry = '{pc: pcq_head.pc, inst: imem_rsp_data};
    assign pcq_entry = '{pc: fetch_pc, inst: 32'h0};
    assign unused_pcq_inst = ^pcq_head.inst;

    // Holds the fetch address of every in-flight request so responses get their pc back.
    fetch_fifo #(.DEPTH(DEPTH)) u_pc_queue (
        .clock     (clock),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (req_fire),
        .push_data (pcq_entry),
        .pop       (rsp_keep),
        .head      (pcq_head),
        .count     (pcq_count)
    );

    fetch_fifo #(.DEPTH(DEPTH)) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (rsp_keep),
        .push_data (rsp_entry),
        .pop       (pop_fire),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_comb begin
        drop_next = drop_count;
        if (redirect_valid) begin
            drop_next = outstanding - CW'(rsp_take);
        end else if (rsp_take && (drop_count != '0)) begin
            drop_next = drop_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_count  <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
            drop_count  <= drop_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (redirect_valid && (drop_next != '0)) state_next = DRAIN;
            DRAIN:   if (drop_next == '0) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Requests are held off during reset so nothing leaks out before the stream starts.
    always_comb begin
        imem_req_valid = reset && (state == RUN) && !redirect_valid && (credit_used < CREDIT_LIMIT);
        inst = NOP_INST;
        pc   = 32'h0;
        if (fifo_count != '0) begin
            inst = fifo_head.inst;
            pc   = fifo_head.pc;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: an in-order memory model with programmable latency
// whose instruction word is ~address, plus a decode-side monitor.
module tb_ifu_fetch;
    import fetch_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [31:0]  imem_req_addr;
    logic         imem_rsp_valid = 1'b0;
    logic [31:0]  imem_rsp_data  = 32'h0;
    logic [31:0]  inst;
    logic [31:0]  pc;
    logic [31:0]  snpc;
    logic         valid_next;
    logic         ready_next;
    logic [1:0]   outstanding;
    fetch_state_e state;
    logic [1:0]   drop_count;

    int tests = 0;
    int fails = 0;

    ifu_fetch #(.RESET_PC(32'h8000_0000), .DEPTH(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst           (inst),
        .pc             (pc),
        .snpc           (snpc),
        .valid_next     (valid_next),
        .ready_next     (ready_next),
        .outstanding    (outstanding),
        .state          (state),
        .drop_count     (drop_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Memory model: request handshakes are sampled mid-cycle, responses appear
    // mem_lat edges after the accepting edge, in order.
    logic        hs_s   = 1'b0;
    logic [31:0] addr_s = 32'h0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          edge_n  = 0;
    int          mem_lat = 1;
    int          req_cnt = 0;

    always @(negedge clock) begin
        hs_s   = reset && imem_req_valid && imem_req_ready;
        addr_s = imem_req_addr;
        if (hs_s) req_cnt++;
    end

    always @(posedge clock) begin
        #1;
        edge_n++;
        if (!reset) begin
            pend_addr.delete();
            pend_due.delete();
            imem_rsp_valid = 1'b0;
        end else begin
            if (hs_s) begin
                pend_addr.push_back(addr_s);
                pend_due.push_back(edge_n + mem_lat - 1);
            end
            if (pend_addr.size() != 0 && pend_due[0] <= edge_n) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~pend_addr[0];
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // Decode-side monitor: records every accepted entry.
    logic [31:0] got_pc[$];
    logic [31:0] got_snpc[$];

    always @(negedge clock) begin
        if (reset && valid_next && ready_next) begin
            got_pc.push_back(pc);
            got_snpc.push_back(snpc);
            check("inst_of_pc", inst, ~pc);
            check("snpc_of_pc", snpc, pc + 32'd4);
        end
    end

    task automatic wait_got(input int n, input string tag);
        for (int i = 0; i < 40 && got_pc.size() < n; i++) tick();
        check(tag, 32'(got_pc.size() >= n), 32'd1);
    endtask

    task automatic drain();
        imem_req_ready = 1'b0;
        ready_next     = 1'b1;
        for (int i = 0; i < 40 && !(outstanding == 2'd0 && !valid_next); i++) tick();
        check("drain_idle", 32'(outstanding == 2'd0 && !valid_next), 32'd1);
        got_pc.delete();
        got_snpc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        ready_next     = 1'b0;
        tick();
        tick();

        check("rst_valid_next", 32'(valid_next), 32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_pc", pc, 32'h0);
        check("rst_snpc", snpc, 32'h4);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_state", 32'(state), 32'(RUN));

        // Decode stalled from reset release: exactly two requests fill the FIFO.
        reset = 1'b1;
        repeat (10) tick();
        check("stall_req_cnt", 32'(req_cnt), 32'd2);
        check("stall_valid", 32'(valid_next), 32'd1);
        check("stall_head_pc", pc, 32'h8000_0000);
        check("stall_head_inst", inst, 32'h7FFF_FFFF);
        check("stall_outstanding", 32'(outstanding), 32'd0);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);

        // Release decode: stream resumes in order with no loss or duplicate.
        ready_next = 1'b1;
        wait_got(4, "run_wait");
        check("run_pc0", got_pc[0], 32'h8000_0000);
        check("run_pc1", got_pc[1], 32'h8000_0004);
        check("run_pc2", got_pc[2], 32'h8000_0008);
        check("run_pc3", got_pc[3], 32'h8000_000C);

        // Redirect with two requests in flight at latency 3.
        drain();
        mem_lat        = 3;
        imem_req_ready = 1'b1;
        tick();
        tick();
        check("rd3_outstanding", 32'(outstanding), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        #1;
        check("rd3_valid_forced", 32'(valid_next), 32'd0);
        check("rd3_req_blocked", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        check("rd3_state_a", 32'(state), 32'(DRAIN));
        check("rd3_drop_a", 32'(drop_count), 32'd2);
        tick();
        check("rd3_state_b", 32'(state), 32'(DRAIN));
        check("rd3_drop_b", 32'(drop_count), 32'd1);
        tick();
        check("rd3_state_c", 32'(state), 32'(RUN));
        check("rd3_out_c", 32'(outstanding), 32'd0);
        check("rd3_req_addr", imem_req_addr, 32'h8000_0100);
        wait_got(2, "rd3_wait");
        check("rd3_pc0", got_pc[0], 32'h8000_0100);
        check("rd3_pc1", got_pc[1], 32'h8000_0104);

        // Redirect in the same cycle as a response: that response is dropped too.
        drain();
        imem_req_ready = 1'b1;
        tick();
        tick();
        tick();
        check("rd4_outstanding", 32'(outstanding), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0203;
        tick();
        redirect_valid = 1'b0;
        check("rd4_state_a", 32'(state), 32'(DRAIN));
        check("rd4_drop_a", 32'(drop_count), 32'd1);
        check("rd4_out_a", 32'(outstanding), 32'd1);
        tick();
        check("rd4_state_b", 32'(state), 32'(RUN));
        check("rd4_out_b", 32'(outstanding), 32'd0);
        check("rd4_req_addr", imem_req_addr, 32'h8000_0200);
        wait_got(1, "rd4_wait");
        check("rd4_pc0", got_pc[0], 32'h8000_0200);

        // Redirect to the top word: PC wraps to zero.
        drain();
        mem_lat        = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        check("wrap_state", 32'(state), 32'(RUN));
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        wait_got(2, "wrap_wait");
        check("wrap_pc0", got_pc[0], 32'hFFFF_FFFC);
        check("wrap_snpc0", got_snpc[0], 32'h0000_0000);
        check("wrap_pc1", got_pc[1], 32'h0000_0000);

        // Reset mid-stream with two requests outstanding.
        drain();
        mem_lat        = 3;
        imem_req_ready = 1'b1;
        tick();
        tick();
        check("mrst_outstanding_pre", 32'(outstanding), 32'd2);
        reset = 1'b0;
        tick();
        check("mrst_valid_next", 32'(valid_next), 32'd0);
        check("mrst_outstanding", 32'(outstanding), 32'd0);
        check("mrst_inst", inst, 32'h0000_0013);
        check("mrst_pc", pc, 32'h0);
        check("mrst_drop", 32'(drop_count), 32'd0);
        check("mrst_req_valid", 32'(imem_req_valid), 32'd0);
        reset = 1'b1;
        #1;
        check("mrst_req_valid_rel", 32'(imem_req_valid), 32'd1);
        check("mrst_req_addr", imem_req_addr, 32'h8000_0000);
        got_pc.delete();
        got_snpc.delete();
        wait_got(1, "mrst_wait");
        check("mrst_pc0", got_pc[0], 32'h8000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
